// File: rtl/conv2_window_accum.sv
// Multi-channel windowed accumulator. Each channel sums WIN signed samples,
// then rounds and shifts the sum, adds a bias, optionally applies ReLU and
// saturates to DW bits. The result is held in a valid/ready output register.
module conv2_window_accum #(
    parameter int NCH   = 3,
    parameter int DW    = 12,
    parameter int WIN   = 25,
    parameter int SHIFT = 1,
    parameter int RELU  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NCH*DW-1:0] in_data,
    input  logic [NCH*DW-1:0] bias,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NCH*DW-1:0] out_data,
    output logic [NCH-1:0]    out_sat
);

    localparam int CW = $clog2(WIN);
    localparam int AW = DW + $clog2(WIN) + 1;
    // Two extra bits absorb the rounding constant and the bias add.
    localparam int EW = AW + 2;

    localparam logic [CW-1:0]        LAST = CW'(WIN - 1);
    localparam logic signed [EW-1:0] RND  = EW'((2 ** SHIFT) / 2);
    localparam logic signed [EW-1:0] MAXV = EW'((2 ** (DW - 1)) - 1);
    localparam logic signed [EW-1:0] MINV = EW'(-(2 ** (DW - 1)));

    logic [CW-1:0]        cnt;
    logic signed [AW-1:0] acc     [NCH];
    logic signed [DW-1:0] in_ch   [NCH];
    logic signed [DW-1:0] bias_ch [NCH];
    logic signed [AW-1:0] acc_nx  [NCH];
    logic signed [EW-1:0] sum_ext [NCH];
    logic signed [EW-1:0] rnd_val [NCH];
    logic signed [EW-1:0] res_val [NCH];
    logic [NCH*DW-1:0]    res_data;
    logic [NCH-1:0]       res_sat;

    logic last;
    logic accept;
    logic close;

    assign last     = (cnt == LAST);
    assign in_ready = !(last && out_valid && !out_ready);
    assign accept   = in_valid && in_ready && !clear;
    assign close    = accept && last;

    // Per-channel running sum and the full closing-beat result pipeline.
    always_comb begin
        res_data = '0;
        res_sat  = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            in_ch[c]   = in_data[c*DW +: DW];
            bias_ch[c] = bias[c*DW +: DW];
            acc_nx[c]  = acc[c] + AW'(in_ch[c]);
            sum_ext[c] = EW'(acc_nx[c]);
            // RND is zero when SHIFT is zero, so one expression covers both cases.
            rnd_val[c] = (sum_ext[c] + RND) >>> SHIFT;
            res_val[c] = rnd_val[c] + EW'(bias_ch[c]);
            if (RELU != 0 && res_val[c] < 0) begin
                res_val[c] = '0;
            end
            if (res_val[c] > MAXV) begin
                res_val[c] = MAXV;
                res_sat[c] = 1'b1;
            end else if (res_val[c] < MINV) begin
                res_val[c] = MINV;
                res_sat[c] = 1'b1;
            end
            res_data[c*DW +: DW] = res_val[c][DW-1:0];
        end
    end

    // Sample counter and accumulators; clear flushes, closing beat restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            for (int unsigned c = 0; c < NCH; c++) acc[c] <= '0;
        end else if (clear) begin
            cnt <= '0;
            for (int unsigned c = 0; c < NCH; c++) acc[c] <= '0;
        end else if (accept) begin
            if (last) begin
                cnt <= '0;
                for (int unsigned c = 0; c < NCH; c++) acc[c] <= '0;
            end else begin
                cnt <= cnt + CW'(1);
                for (int unsigned c = 0; c < NCH; c++) acc[c] <= acc_nx[c];
            end
        end
    end

    // Output holding register; a closing beat reloads even while draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= '0;
        end else if (close) begin
            out_valid <= 1'b1;
            out_data  <= res_data;
            out_sat   <= res_sat;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv2_window_accum.sv
// Bench for conv2_window_accum: two instances (ReLU on / off) share stimulus;
// a cycle model predicts in_ready/out_valid and a scoreboard queue holds results.
module tb_conv2_window_accum;

    localparam int NCH = 3;
    localparam int DW  = 12;
    localparam int WIN = 25;

    typedef struct {
        logic [NCH*DW-1:0] d1;
        logic [NCH-1:0]    s1;
        logic [NCH*DW-1:0] d0;
        logic [NCH-1:0]    s0;
    } exp_t;

    typedef struct {
        int d[3];
        int b[3];
        int e1[3];
        int s1;
        int e0[3];
        int s0;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [NCH*DW-1:0] in_data;
    logic [NCH*DW-1:0] bias;
    logic              clear;
    logic              out_ready;
    logic              in_ready_a, in_ready_b;
    logic              out_valid_a, out_valid_b;
    logic [NCH*DW-1:0] out_data_a, out_data_b;
    logic [NCH-1:0]    out_sat_a, out_sat_b;

    int checks   = 0;
    int failures = 0;

    int   m_cnt;
    int   m_acc[3];
    bit   m_ov;
    exp_t m_held;
    exp_t sbq[$];
    bit   last_acc;

    conv2_window_accum #(.NCH(NCH), .DW(DW), .WIN(WIN), .SHIFT(1), .RELU(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .bias(bias), .clear(clear), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_data(out_data_a), .out_sat(out_sat_a)
    );

    conv2_window_accum #(.NCH(NCH), .DW(DW), .WIN(WIN), .SHIFT(1), .RELU(0)) dut_nr (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .bias(bias), .clear(clear), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_data(out_data_b), .out_sat(out_sat_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [NCH*DW-1:0] pack3(input int a, input int b, input int c);
        logic [DW-1:0] x, y, z;
        x = DW'(a);
        y = DW'(b);
        z = DW'(c);
        return {z, y, x};
    endfunction

    function automatic int chan(input logic [NCH*DW-1:0] v, input int c);
        logic signed [DW-1:0] t;
        t = v[c*DW +: DW];
        return int'(t);
    endfunction

    // Reference arithmetic for SHIFT=1: floor((s+1)/2) + bias, ReLU, clamp.
    function automatic int model_res(input int s, input int b, input bit relu, output bit sat);
        int x, r, v;
        x = s + 1;
        r = (x >= 0) ? x / 2 : -((-x + 1) / 2);
        v = r + b;
        if (relu && v < 0) v = 0;
        sat = 1'b0;
        if (v > 2047) begin v = 2047; sat = 1'b1; end
        else if (v < -2048) begin v = -2048; sat = 1'b1; end
        return v;
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        for (int c = 0; c < 3; c++) m_acc[c] = 0;
        m_ov = 1'b0;
        m_held = '{default: '0};
        sbq.delete();
    endtask

    // One clock: check in_ready, advance model across the edge, check outputs.
    task automatic step();
        bit   exp_rdy, acc_b, close_b, st;
        exp_t e;
        int   v1[3], v0[3];
        #2;
        exp_rdy = !(m_cnt == WIN - 1 && m_ov && !out_ready);
        chk("in_ready", {63'd0, in_ready_a}, {63'd0, exp_rdy});
        chk("in_ready_nr", {63'd0, in_ready_b}, {63'd0, exp_rdy});
        acc_b   = in_valid && exp_rdy && !clear;
        close_b = acc_b && (m_cnt == WIN - 1);
        last_acc = acc_b;
        @(posedge clk);
        if (clear) begin
            m_cnt = 0;
            for (int c = 0; c < 3; c++) m_acc[c] = 0;
        end else if (acc_b) begin
            if (close_b) begin
                e.s1 = '0;
                e.s0 = '0;
                for (int c = 0; c < 3; c++) begin
                    v1[c] = model_res(m_acc[c] + chan(in_data, c), chan(bias, c), 1'b1, st);
                    e.s1[c] = st;
                    v0[c] = model_res(m_acc[c] + chan(in_data, c), chan(bias, c), 1'b0, st);
                    e.s0[c] = st;
                    m_acc[c] = 0;
                end
                e.d1 = pack3(v1[0], v1[1], v1[2]);
                e.d0 = pack3(v0[0], v0[1], v0[2]);
                sbq.push_back(e);
                m_cnt = 0;
            end else begin
                for (int c = 0; c < 3; c++) m_acc[c] += chan(in_data, c);
                m_cnt++;
            end
        end
        if (close_b) m_ov = 1'b1;
        else if (m_ov && out_ready) m_ov = 1'b0;
        #1;
        chk("out_valid", {63'd0, out_valid_a}, {63'd0, m_ov});
        chk("out_valid_nr", {63'd0, out_valid_b}, {63'd0, m_ov});
        if (close_b) begin
            if (sbq.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                m_held = sbq.pop_front();
                chk("out_data", 64'(out_data_a), 64'(m_held.d1));
                chk("out_sat", 64'(out_sat_a), 64'(m_held.s1));
                chk("out_data_nr", 64'(out_data_b), 64'(m_held.d0));
                chk("out_sat_nr", 64'(out_sat_b), 64'(m_held.s0));
            end
        end else if (m_ov) begin
            chk("hold_data", 64'(out_data_a), 64'(m_held.d1));
            chk("hold_data_nr", 64'(out_data_b), 64'(m_held.d0));
            chk("hold_sat", 64'(out_sat_a), 64'(m_held.s1));
        end
    endtask

    task automatic send(input logic [NCH*DW-1:0] d, input logic [NCH*DW-1:0] b);
        int guard;
        in_valid = 1'b1;
        in_data  = d;
        bias     = b;
        guard    = 0;
        last_acc = 1'b0;
        while (!last_acc && guard < 50) begin
            step();
            guard++;
        end
        if (!last_acc) chk("send_timeout", 64'd1, 64'd0);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        chk("rst_out_valid", {63'd0, out_valid_a}, 64'd0);
        chk("rst_out_data", 64'(out_data_a), 64'd0);
        chk("rst_out_sat", 64'(out_sat_a), 64'd0);
        chk("rst_out_data_nr", 64'(out_data_b), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {63'd0, in_ready_a}, 64'd1);
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{'{10, 10, 10}, '{0, 0, 0}, '{125, 125, 125}, 0, '{125, 125, 125}, 0};
        tbl[1] = '{'{-4, -4, -4}, '{0, 0, 0}, '{0, 0, 0}, 0, '{-50, -50, -50}, 0};
        tbl[2] = '{'{2047, 2047, 2047}, '{5, 5, 5}, '{2047, 2047, 2047}, 7, '{2047, 2047, 2047}, 7};
        tbl[3] = '{'{-2048, -2048, -2048}, '{0, 0, 0}, '{0, 0, 0}, 0, '{-2048, -2048, -2048}, 7};
        tbl[4] = '{'{3, -1, 7}, '{-40, 0, 100}, '{0, 0, 188}, 0, '{-2, -12, 188}, 0};
        tbl[5] = '{'{-1, 1, 0}, '{0, 2047, -2048}, '{0, 2047, 0}, 2, '{-12, 2047, -2048}, 2};

        in_valid  = 1'b0;
        in_data   = '0;
        bias      = '0;
        clear     = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        #1;
        do_reset();

        // Table-driven windows with the output always drained.
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < WIN; k++)
                send(pack3(tbl[i].d[0], tbl[i].d[1], tbl[i].d[2]),
                     pack3(tbl[i].b[0], tbl[i].b[1], tbl[i].b[2]));
            chk($sformatf("tbl%0d_data", i), 64'(out_data_a),
                64'(pack3(tbl[i].e1[0], tbl[i].e1[1], tbl[i].e1[2])));
            chk($sformatf("tbl%0d_sat", i), 64'(out_sat_a), 64'(tbl[i].s1));
            chk($sformatf("tbl%0d_data_nr", i), 64'(out_data_b),
                64'(pack3(tbl[i].e0[0], tbl[i].e0[1], tbl[i].e0[2])));
            chk($sformatf("tbl%0d_sat_nr", i), 64'(out_sat_b), 64'(tbl[i].s0));
            step();
        end

        // Backpressure: result pending, next window streams, closing beat stalls.
        out_ready = 1'b0;
        for (int k = 0; k < WIN; k++) send(pack3(10, 10, 10), '0);
        for (int k = 0; k < WIN - 1; k++) send(pack3(5, 5, 5), '0);
        in_valid = 1'b1;
        in_data  = pack3(5, 5, 5);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_stalled", {63'd0, last_acc}, 64'd0);
        end
        chk("bp_held", 64'(out_data_a), 64'(pack3(125, 125, 125)));
        out_ready = 1'b1;
        step();
        chk("bp_accept", {63'd0, last_acc}, 64'd1);
        chk("bp_new", 64'(out_data_a), 64'(pack3(63, 63, 63)));
        chk("bp_valid_stays", {63'd0, out_valid_a}, 64'd1);
        in_valid = 1'b0;
        step();
        step();

        // Clear after 10 beats; a beat presented with clear is dropped.
        for (int k = 0; k < 10; k++) send(pack3(9, -3, 100), pack3(k, -k, 77));
        in_valid = 1'b1;
        in_data  = pack3(400, 400, 400);
        clear    = 1'b1;
        step();
        chk("clear_drop", {63'd0, last_acc}, 64'd0);
        clear    = 1'b0;
        in_valid = 1'b0;
        step();
        for (int k = 0; k < WIN - 1; k++) send(pack3(2, 2, 2), pack3(k, 300, -k));
        send(pack3(2, 2, 2), pack3(-7, -7, -7));
        chk("clear_bias", 64'(out_data_a), 64'(pack3(18, 18, 18)));
        step();

        // Reset at cnt == 12 discards the partial window.
        for (int k = 0; k < 12; k++) send(pack3(50, 50, 50), '0);
        do_reset();
        step();
        step();
        chk("midrst_no_valid", {63'd0, out_valid_a}, 64'd0);
        for (int k = 0; k < WIN; k++) send(pack3(7, 7, 7), pack3(3, 3, 3));
        chk("midrst_result", 64'(out_data_a), 64'(pack3(91, 91, 91)));
        step();
        step();

        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv2_window_accum.md
CONV2_WINDOW_ACCUM -- requirements
Module: conv2_window_accum

Interface
Parameters:
REQ-001 The block SHALL have parameter NCH, default 3, giving the number of parallel channels.
REQ-002 The block SHALL have parameter DW, default 12, giving the signed two's-complement data width of each input, bias and output.
REQ-003 The block SHALL have parameter WIN, default 25, giving the samples accumulated per window (legal range 2..1024).
REQ-004 The block SHALL have parameter SHIFT, default 1, giving the arithmetic right-shift applied to the accumulated sum (legal range 0..8).
REQ-005 The block SHALL have parameter RELU, default 1; when 1, negative results SHALL be clamped to 0.

Ports:
REQ-006 The block SHALL have port clk, input, width 1: clock, rising edge.
REQ-007 The block SHALL have port rst_n, input, width 1: reset, asynchronous, active-low.
REQ-008 The block SHALL have port in_valid, input, width 1: input beat valid.
REQ-009 The block SHALL have port in_ready, output, width 1: block accepts a beat.
REQ-010 The block SHALL have port in_data, input, width NCH*DW: channel c in bits [c*DW +: DW], signed.
REQ-011 The block SHALL have port bias, input, width NCH*DW: per-channel signed bias, sampled on the window-closing beat.
REQ-012 The block SHALL have port clear, input, width 1: synchronous flush of the partial window.
REQ-013 The block SHALL have port out_valid, output, width 1: result held.
REQ-014 The block SHALL have port out_ready, input, width 1: downstream accepts the result.
REQ-015 The block SHALL have port out_data, output, width NCH*DW: per-channel results, same packing as in_data.
REQ-016 The block SHALL have port out_sat, output, width NCH: per-channel saturation flag for the held result.

Function
REQ-017 A beat SHALL be accepted iff in_valid && in_ready at a rising clk edge.
REQ-018 Each channel SHALL have an accumulator of width AW = DW + clog2(WIN) + 1, so that no wrap occurs within a window.
REQ-019 The sample counter cnt SHALL run 0..WIN-1, increment per accepted beat, and wrap to 0 on the beat accepted at cnt == WIN-1 (the window-closing beat).
REQ-020 A non-closing beat SHALL perform acc_c <= acc_c + sext(in_data_c).
REQ-021 On the closing beat, per channel: s = acc_c + sext(in_data_c).
REQ-022 On the closing beat, r = (s + 2^(SHIFT-1)) >>> SHIFT when SHIFT > 0, else r = s (round half toward +inf).
REQ-023 On the closing beat, v = r + sext(bias_c).
REQ-024 On the closing beat, if RELU is set and v < 0, then v = 0.
REQ-025 On the closing beat, v SHALL saturate to [-2^(DW-1), 2^(DW-1)-1], with out_sat[c] = 1 iff clamping occurred (ReLU clamping is not saturation).
REQ-026 On the closing beat, the block SHALL load out_data/out_sat, set out_valid = 1 and zero all accumulators, all in the same edge (latency: 1 cycle from the closing beat to out_valid).
REQ-027 out_valid, out_data and out_sat SHALL hold stable until the edge where out_valid && out_ready; out_valid SHALL then drop unless a new closing beat is accepted in that same edge, in which case the new result SHALL load and out_valid SHALL stay 1.
REQ-028 in_ready SHALL be the combinational function !(cnt == WIN-1 && out_valid && !out_ready); non-closing beats SHALL be accepted while a result is pending.
REQ-029 clear = 1 SHALL zero cnt and all accumulators and discard any beat presented that cycle; the output register and out_valid SHALL be unaffected.
REQ-030 in_ready SHALL remain asserted during clear.
REQ-031 When in_valid && clear occur together, clear SHALL win and no accumulation SHALL happen.
REQ-032 in_valid without acceptance SHALL leave all state unchanged.

Reset
REQ-033 While rst_n = 0: cnt = 0, all accumulators = 0, out_valid = 0, out_data = 0, out_sat = 0.
REQ-034 Reset mid-window SHALL discard the partial sums, with no output produced.
REQ-035 After reset release, in_ready SHALL be 1.
REQ-036 The first accepted beat after reset release SHALL be sample 0 of a new window.

Verification
Defaults NCH=3, DW=12, WIN=25, SHIFT=1, unless stated.
REQ-037 Basic: 25 beats with all channels = 10, bias 0 -> one cycle after the 25th beat, out_valid = 1 and each out = 125 ((250+1)>>>1), out_sat = 0.
REQ-038 Negative/ReLU: 25 beats of -4, bias 0 -> RELU=1: out = 0, sat = 0; RELU=0: out = -50, sat = 0.
REQ-039 Saturation: 25 beats of 2047, bias 5 -> out = 2047, out_sat = 3'b111; 25 beats of -2048 with RELU=0 -> out = -2048, out_sat = 3'b111.
REQ-040 Backpressure: out_ready = 0 with a result pending; stream the next 24 beats -> all accepted, the 25th is stalled (in_ready = 0) and out_data is stable; raise out_ready -> the closing beat is accepted in the same edge, the new result loads and out_valid stays 1.
REQ-041 Clear/bias: clear after 10 beats, then 25 beats of 2 with bias = -7 -> out = 25-7 = 18.
REQ-042 Clear/reset priority: in_valid asserted together with clear -> that beat is dropped; rst_n pulsed at cnt = 12 -> no out_valid, and the next 25 beats produce a correct result.
